// File: rtl/vdp_reg_writer.sv
// Host-side initiator for the VDP mode-1 control port: queues (reg, value) requests
// and emits each one as a value-byte / control-byte write pair, with optional resync reads.
module vdp_reg_writer #(
    parameter int DEPTH         = 4,
    parameter int GAP           = 2,
    parameter int SYNC_ON_START = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_reg,
    input  logic [7:0]               req_val,
    input  logic                     resync,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wr_tick,
    output logic                     rd_tick,
    output logic [7:0]               dout
);

    // state   | meaning
    // S_IDLE  | pick next job: pending resync first, then FIFO head
    // S_SYNC  | rd_tick cycle, resynchronises the receiver's write phase
    // S_B0    | wr_tick carrying the value byte
    // S_B1    | wr_tick carrying the control byte {2'b10,3'b000,reg}
    // S_WAIT  | GAP idle cycles, then continue to wait_ret
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_B0, S_B1, S_WAIT} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (GAP < 2) ? 1 : $clog2(GAP);
    localparam logic [CW-1:0] WAIT_LOAD = (GAP == 0) ? '0 : CW'(GAP - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

    logic [10:0]   mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [LW-1:0] count, count_next;
    logic          push, pop, fifo_empty;

    state_t        state, state_next, wait_ret, wait_ret_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    hold_reg;
    logic          sync_pending, sync_next, sync_clr;
    logic          wr_next, rd_next, busy_next;
    logic [7:0]    dout_next;

    assign push       = req_valid & req_ready;
    assign fifo_empty = (count == '0);
    assign level      = count;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + LW'(1);
            2'b01:   count_next = count - LW'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        wait_ret_next = wait_ret;
        pop           = 1'b0;
        sync_clr      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (sync_pending) begin
                    state_next = S_SYNC;
                    sync_clr   = 1'b1;
                end else if (!fifo_empty) begin
                    state_next = S_B0;
                    pop        = 1'b1;
                end
            end
            S_SYNC, S_B1: begin
                if (GAP == 0) begin
                    state_next = S_IDLE;
                end else begin
                    state_next    = S_WAIT;
                    cnt_next      = WAIT_LOAD;
                    wait_ret_next = S_IDLE;
                end
            end
            S_B0: begin
                if (GAP == 0) begin
                    state_next = S_B1;
                end else begin
                    state_next    = S_WAIT;
                    cnt_next      = WAIT_LOAD;
                    wait_ret_next = S_B1;
                end
            end
            S_WAIT: begin
                if (cnt == '0) state_next = wait_ret;
                else           cnt_next   = cnt - CW'(1);
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so a tick coincides with its state.
    always_comb begin
        wr_next   = (state_next == S_B0) || (state_next == S_B1);
        rd_next   = (state_next == S_SYNC);
        dout_next = dout;
        unique case (state_next)
            S_B0:    dout_next = mem[rptr][7:0];
            S_B1:    dout_next = {5'b10000, hold_reg};
            S_SYNC:  dout_next = 8'h00;
            default: dout_next = dout;
        endcase
        // A new pulse in the same cycle as service must not be lost.
        sync_next = resync ? 1'b1 : (sync_clr ? 1'b0 : sync_pending);
        busy_next = (count_next != '0) || sync_next || (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {req_reg, req_val};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_ret     <= S_IDLE;
            cnt          <= '0;
            hold_reg     <= '0;
            sync_pending <= (SYNC_ON_START != 0);
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            req_ready    <= 1'b1;
            busy         <= (SYNC_ON_START != 0);
            wr_tick      <= 1'b0;
            rd_tick      <= 1'b0;
            dout         <= 8'h00;
        end else begin
            state        <= state_next;
            wait_ret     <= wait_ret_next;
            cnt          <= cnt_next;
            sync_pending <= sync_next;
            count        <= count_next;
            req_ready    <= (count_next != FULL_LVL);
            busy         <= busy_next;
            wr_tick      <= wr_next;
            rd_tick      <= rd_next;
            dout         <= dout_next;
            if (push) wptr <= wptr + PW'(1);
            if (pop) begin
                rptr     <= rptr + PW'(1);
                hold_reg <= mem[rptr][10:8];
            end
        end
    end

endmodule
